// File: rtl/i2c_data_path_engine.sv
`timescale 1ns/1ps
// I2C bit-level data path: serialises address/data bytes onto SDA and deserialises read bytes, MSB first.
// Latency: one bit per drive/sample tick pair; done_o/data_valid_o are registered and pulse the cycle after the deciding sample tick.
// Backpressure: cmd_ready_o is high only in IDLE with no START/STOP override; commands presented while busy are dropped.
//
// Ports:
//   i2c_core_clk_i / i2c_core_rst_ni : clock, synchronous active-low reset
//   cmd_i, cmd_valid_i, cmd_ready_o   : command handshake (01 ADDR, 10 WRITE, 11 READ)
//   data_i, addr_i, rw_i, ack_i       : operands captured when a command is accepted
//   drive_tick_i, sample_tick_i       : SCL-low / SCL-high midpoint strobes from the bit timer
//   sda_low_i, abort_i, sda_i         : START/STOP override, transfer kill, sampled SDA line
//   i2c_sda_o                         : SDA drive (1 = released)
//   data_from_sda_o, data_valid_o     : received byte and its 1-cycle strobe
//   ack_received_o, nack_o            : result of the last TX ACK slot
//   done_o, busy_o                    : command-complete pulse, engine busy
module i2c_data_path_engine #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 7
) (
  input  logic                 i2c_core_clk_i,
  input  logic                 i2c_core_rst_ni,
  input  logic [DATA_SIZE-1:0] data_i,
  input  logic [ADDR_SIZE-1:0] addr_i,
  input  logic                 rw_i,
  input  logic                 ack_i,
  input  logic [1:0]           cmd_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 drive_tick_i,
  input  logic                 sample_tick_i,
  input  logic                 sda_low_i,
  input  logic                 abort_i,
  input  logic                 sda_i,
  output logic                 i2c_sda_o,
  output logic [DATA_SIZE-1:0] data_from_sda_o,
  output logic                 data_valid_o,
  output logic                 ack_received_o,
  output logic                 nack_o,
  output logic                 done_o,
  output logic                 busy_o
);

  // Address phase carries the R/W bit as its LSB.
  localparam int AW    = ADDR_SIZE + 1;
  localparam int SR_W  = (AW > DATA_SIZE) ? AW : DATA_SIZE;
  localparam int CNT_W = $clog2(SR_W);

  typedef enum logic [2:0] {
    IDLE,
    TX,
    TX_ACK,
    RX,
    RX_ACK
  } state_t;

  state_t            state_q;
  logic [SR_W-1:0]   shift_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ack_lat_q;

  assign busy_o      = (state_q != IDLE);
  assign cmd_ready_o = (state_q == IDLE) && !sda_low_i;

  always_ff @(posedge i2c_core_clk_i) begin
    if (!i2c_core_rst_ni) begin
      state_q         <= IDLE;
      shift_q         <= '0;
      cnt_q           <= '0;
      ack_lat_q       <= 1'b0;
      i2c_sda_o       <= 1'b1;
      data_from_sda_o <= '0;
      data_valid_o    <= 1'b0;
      ack_received_o  <= 1'b0;
      nack_o          <= 1'b0;
      done_o          <= 1'b0;
    end else begin
      done_o       <= 1'b0;
      data_valid_o <= 1'b0;

      if (abort_i) begin
        // Kill the transfer outright; ACK/NACK history is deliberately kept.
        state_q   <= IDLE;
        i2c_sda_o <= 1'b1;
      end else begin
        // Within each busy state the sample branch comes first, so a drive
        // tick that coincides with a sample tick is dropped.
        case (state_q)
          IDLE: begin
            if (drive_tick_i && !sample_tick_i) i2c_sda_o <= 1'b1;
            if (cmd_valid_i && cmd_ready_o) begin
              case (cmd_i)
                2'b01: begin
                  // Left-align so the MSB of the phase sits at the top of the register.
                  shift_q <= SR_W'({addr_i, rw_i}) << (SR_W - AW);
                  cnt_q   <= CNT_W'(AW - 1);
                  state_q <= TX;
                end
                2'b10: begin
                  shift_q <= SR_W'(data_i) << (SR_W - DATA_SIZE);
                  cnt_q   <= CNT_W'(DATA_SIZE - 1);
                  state_q <= TX;
                end
                2'b11: begin
                  shift_q   <= '0;
                  ack_lat_q <= ack_i;
                  cnt_q     <= CNT_W'(DATA_SIZE - 1);
                  state_q   <= RX;
                end
                default: ;
              endcase
            end
          end

          TX: begin
            if (sample_tick_i) begin
              if (cnt_q == '0) state_q <= TX_ACK;
              else             cnt_q   <= cnt_q - CNT_W'(1);
            end else if (drive_tick_i) begin
              i2c_sda_o <= shift_q[SR_W-1];
              shift_q   <= shift_q << 1;
            end
          end

          TX_ACK: begin
            if (sample_tick_i) begin
              ack_received_o <= ~sda_i;
              nack_o         <= sda_i;
              done_o         <= 1'b1;
              state_q        <= IDLE;
            end else if (drive_tick_i) begin
              i2c_sda_o <= 1'b1;
            end
          end

          RX: begin
            if (sample_tick_i) begin
              shift_q <= {shift_q[SR_W-2:0], sda_i};
              if (cnt_q == '0) begin
                data_from_sda_o <= {shift_q[DATA_SIZE-2:0], sda_i};
                data_valid_o    <= 1'b1;
                state_q         <= RX_ACK;
              end else begin
                cnt_q <= cnt_q - CNT_W'(1);
              end
            end else if (drive_tick_i) begin
              i2c_sda_o <= 1'b1;
            end
          end

          RX_ACK: begin
            if (sample_tick_i) begin
              done_o  <= 1'b1;
              state_q <= IDLE;
            end else if (drive_tick_i) begin
              i2c_sda_o <= ack_lat_q;
            end
          end

          default: state_q <= IDLE;
        endcase
      end

      // START/STOP override wins over every other SDA source, abort included.
      if (sda_low_i) i2c_sda_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2c_data_path_engine.sv
`timescale 1ns/1ps
module tb_i2c_data_path_engine;

  localparam int DS = 8;
  localparam int AS = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DS-1:0] data_i;
  logic [AS-1:0] addr_i;
  logic          rw_i, ack_i;
  logic [1:0]    cmd_i;
  logic          cmd_valid_i, cmd_ready_o;
  logic          drive_tick_i, sample_tick_i, sda_low_i, abort_i, sda_i;
  logic          i2c_sda_o;
  logic [DS-1:0] data_from_sda_o;
  logic          data_valid_o, ack_received_o, nack_o, done_o, busy_o;

  always #5 clk = ~clk;

  i2c_data_path_engine #(.DATA_SIZE(DS), .ADDR_SIZE(AS)) dut (
    .i2c_core_clk_i (clk),
    .i2c_core_rst_ni(rst_n),
    .data_i         (data_i),
    .addr_i         (addr_i),
    .rw_i           (rw_i),
    .ack_i          (ack_i),
    .cmd_i          (cmd_i),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .drive_tick_i   (drive_tick_i),
    .sample_tick_i  (sample_tick_i),
    .sda_low_i      (sda_low_i),
    .abort_i        (abort_i),
    .sda_i          (sda_i),
    .i2c_sda_o      (i2c_sda_o),
    .data_from_sda_o(data_from_sda_o),
    .data_valid_o   (data_valid_o),
    .ack_received_o (ack_received_o),
    .nack_o         (nack_o),
    .done_o         (done_o),
    .busy_o         (busy_o)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Scoreboards: expected SDA bits for TX phases, expected bytes for RX.
  logic          bit_q[$];
  logic [DS-1:0] byte_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] c);
    cmd_i       = c;
    cmd_valid_i = 1'b1;
    step();
    cmd_valid_i = 1'b0;
  endtask

  task automatic drive();
    drive_tick_i = 1'b1;
    step();
    drive_tick_i = 1'b0;
  endtask

  task automatic sample(input logic s);
    sda_i         = s;
    sample_tick_i = 1'b1;
    step();
    sample_tick_i = 1'b0;
  endtask

  task automatic push_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bit_q.push_back(v[i]);
  endtask

  // Runs n TX bits, popping each expected SDA value after its drive tick.
  task automatic run_tx(input int n, input string tag);
    logic e;
    for (int i = 0; i < n; i++) begin
      drive();
      e = bit_q.pop_front();
      check(tag, i2c_sda_o, e);
      sample(1'b0);
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_sda"},   i2c_sda_o, 1);
    check({tag, "_busy"},  busy_o, 0);
    check({tag, "_data"},  data_from_sda_o, 0);
    check({tag, "_dv"},    data_valid_o, 0);
    check({tag, "_done"},  done_o, 0);
    check({tag, "_ack"},   ack_received_o, 0);
    check({tag, "_nack"},  nack_o, 0);
  endtask

  initial begin
    logic [DS-1:0] rx_byte;
    logic [DS-1:0] exp_byte;

    rst_n = 1'b0; data_i = '0; addr_i = '0; rw_i = 1'b0; ack_i = 1'b0;
    cmd_i = 2'b00; cmd_valid_i = 1'b0; drive_tick_i = 1'b0; sample_tick_i = 1'b0;
    sda_low_i = 1'b0; abort_i = 1'b0; sda_i = 1'b1;
    step(); step();
    reset_checks("rst");
    check("rst_ready", cmd_ready_o, 1);
    rst_n = 1'b1;
    step();

    // Reserved command code is ignored.
    issue(2'b00);
    check("cmd00_ignored", busy_o, 0);

    // ADDR 0x50, write direction, slave ACKs.
    addr_i = 7'h50; rw_i = 1'b0;
    issue(2'b01);
    check("addr_busy", busy_o, 1);
    check("addr_ready_low", cmd_ready_o, 0);
    push_bits(32'h0000_00A0, 8);
    run_tx(8, "addr_bit");
    drive();
    check("addr_ack_release", i2c_sda_o, 1);
    check("addr_no_early_done", done_o, 0);
    sample(1'b0);
    check("addr_done", done_o, 1);
    check("addr_ack", ack_received_o, 1);
    check("addr_nack", nack_o, 0);
    check("addr_idle", busy_o, 0);
    step();
    check("addr_done_once", done_o, 0);

    // WRITE 0xA5, slave NACKs.
    data_i = 8'hA5;
    issue(2'b10);
    push_bits(32'h0000_00A5, 8);
    run_tx(8, "wr_bit");
    drive();
    check("wr_ack_release", i2c_sda_o, 1);
    sample(1'b1);
    check("wr_done", done_o, 1);
    check("wr_nack", nack_o, 1);
    check("wr_ack", ack_received_o, 0);

    // READ with NACK latched at accept; ack_i changes afterwards and must not matter.
    ack_i = 1'b1;
    issue(2'b11);
    ack_i = 1'b0;
    exp_byte = 8'h3C;
    byte_q.push_back(exp_byte);
    for (int i = DS - 1; i >= 0; i--) begin
      drive();
      if (i == DS - 1) check("rd_sda_released", i2c_sda_o, 1);
      sample(exp_byte[i]);
      if (i != 0) check("rd_no_early_dv", data_valid_o, 0);
    end
    check("rd_dv", data_valid_o, 1);
    rx_byte = byte_q.pop_front();
    check("rd_data", data_from_sda_o, rx_byte);
    step();
    check("rd_dv_pulse", data_valid_o, 0);
    drive();
    check("rd_ack_slot", i2c_sda_o, 1);
    check("rd_no_early_done", done_o, 0);
    sample(1'b0);
    check("rd_done", done_o, 1);
    check("rd_flags_held", nack_o, 1);

    // WRITE 0xFF aborted after three bits.
    data_i = 8'hFF;
    issue(2'b10);
    push_bits(32'h0000_00FF, 3);
    run_tx(3, "ab_bit");
    drive();
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check("ab_idle", busy_o, 0);
    check("ab_sda", i2c_sda_o, 1);
    check("ab_no_done", done_o, 0);
    check("ab_flags", nack_o, 1);
    step();
    check("ab_no_done_late", done_o, 0);
    check("ab_ready", cmd_ready_o, 1);
    // Next command must be accepted and run normally.
    data_i = 8'h00;
    issue(2'b10);
    check("ab_next_busy", busy_o, 1);
    push_bits(32'h0, 8);
    run_tx(8, "ab_next_bit");
    drive();
    sample(1'b0);
    check("ab_next_done", done_o, 1);
    check("ab_next_ack", ack_received_o, 1);

    // WRITE 0xFF with the START/STOP override held: SDA stays low, bits still count.
    data_i = 8'hFF;
    issue(2'b10);
    sda_low_i = 1'b1;
    check("low_ready", cmd_ready_o, 0);
    addr_i = 7'h11;
    cmd_i = 2'b01; cmd_valid_i = 1'b1;
    push_bits(32'h0, 8);
    run_tx(8, "low_bit");
    cmd_valid_i = 1'b0;
    sda_low_i = 1'b0;
    drive();
    check("low_reached_ack", i2c_sda_o, 1);
    sample(1'b1);
    check("low_done", done_o, 1);
    check("low_nack", nack_o, 1);
    step();
    check("low_busy_cmd_ignored", busy_o, 0);

    // Reset in the middle of a READ.
    issue(2'b11);
    for (int i = 0; i < 4; i++) begin
      drive();
      sample(1'b1);
    end
    rst_n = 1'b0;
    step();
    reset_checks("midrst");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("midrst_no_dv", data_valid_o, 0);
    end

    if (bit_q.size() != 0 || byte_q.size() != 0)
      $display("note: scoreboard not empty");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
